// File: rtl/fir_pkg.sv
// Shared constants for the I2C-configurable FIR filter: datapath sizes, register map
// and I2C target state codes.
package fir_pkg;

  localparam int unsigned TAPS  = 8;
  localparam int unsigned DW    = 16;
  localparam int unsigned SHIFT = 14;
  localparam int unsigned ACC_W = 36;

  localparam logic [7:0] COEF_BASE = 8'h00;
  localparam logic [7:0] COEF_LAST = 8'h0F;
  localparam logic [7:0] CTRL_ADDR = 8'h10;
  localparam logic [7:0] STATUS_ADDR = 8'h11;
  localparam logic [7:0] ID_ADDR = 8'h12;
  localparam logic [7:0] ID_VAL = 8'hF1;
  localparam logic [7:0] PTR_WRAP = 8'h1F;

  localparam logic [DW-1:0] COEF0_RST = 16'h4000;

  localparam logic [3:0] StIdle    = 4'd0;
  localparam logic [3:0] StAddr    = 4'd1;
  localparam logic [3:0] StAckAddr = 4'd2;
  localparam logic [3:0] StWrPtr   = 4'd3;
  localparam logic [3:0] StWrData  = 4'd4;
  localparam logic [3:0] StAckWr   = 4'd5;
  localparam logic [3:0] StRdData  = 4'd6;
  localparam logic [3:0] StRdAck   = 4'd7;

endpackage

// File: rtl/i2c_reg_target.sv
// I2C target with byte-addressed register access: pad synchronizers, START/STOP
// detection and the transfer state machine. Register storage lives in the parent.
module i2c_reg_target
  import fir_pkg::*;
#(
  parameter logic [6:0] I2C_ADDR = 7'h50
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       scl_pad,
  input  logic       sda_pad,
  output logic       sda_release,
  output logic       wr_en,
  output logic [7:0] wr_addr,
  output logic [7:0] wr_data,
  output logic [7:0] rd_addr,
  input  logic [7:0] rd_data,
  output logic [7:0] last_byte,
  output logic       busy,
  output logic [3:0] state
);

  logic [1:0] scl_sync, sda_sync;
  logic       scl, sda, scl_prev, sda_prev;
  logic       scl_rise, scl_fall, start_det, stop_det, byte_done;
  logic [3:0] state_q, bit_cnt;
  logic [7:0] shreg, pointer, ptr_next;

  assign scl       = scl_sync[1];
  assign sda       = sda_sync[1];
  assign scl_rise  = scl & ~scl_prev;
  assign scl_fall  = ~scl & scl_prev;
  // SCL must be high on both samples so SDA moves around SCL edges never look like START/STOP
  assign start_det = scl & scl_prev & sda_prev & ~sda;
  assign stop_det  = scl & scl_prev & ~sda_prev & sda;
  assign byte_done = scl_fall && (bit_cnt == 4'd8);
  assign ptr_next  = (pointer == PTR_WRAP) ? 8'h00 : pointer + 8'h01;

  assign wr_en   = (state_q == StWrData) && byte_done;
  assign wr_addr = pointer;
  assign wr_data = shreg;
  assign rd_addr = pointer;
  assign state   = state_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      scl_sync    <= 2'b11;
      sda_sync    <= 2'b11;
      scl_prev    <= 1'b1;
      sda_prev    <= 1'b1;
      state_q     <= StIdle;
      bit_cnt     <= '0;
      shreg       <= '0;
      pointer     <= '0;
      last_byte   <= '0;
      busy        <= 1'b0;
      sda_release <= 1'b1;
    end else begin
      scl_sync <= {scl_sync[0], scl_pad};
      sda_sync <= {sda_sync[0], sda_pad};
      scl_prev <= scl;
      sda_prev <= sda;
      if (start_det) begin
        state_q     <= StAddr;
        bit_cnt     <= '0;
        busy        <= 1'b1;
        sda_release <= 1'b1;
      end else if (stop_det) begin
        state_q     <= StIdle;
        busy        <= 1'b0;
        sda_release <= 1'b1;
      end else begin
        case (state_q)
          StAddr, StWrPtr, StWrData: begin
            if (scl_rise) begin
              shreg   <= {shreg[6:0], sda};
              bit_cnt <= bit_cnt + 4'd1;
            end else if (byte_done) begin
              last_byte <= shreg;
              bit_cnt   <= '0;
              if (state_q == StAddr) begin
                if (shreg[7:1] == I2C_ADDR) begin
                  state_q     <= StAckAddr;
                  sda_release <= 1'b0;
                end else begin
                  state_q <= StIdle;
                end
              end else begin
                state_q     <= StAckWr;
                sda_release <= 1'b0;
                pointer     <= (state_q == StWrPtr) ? shreg : ptr_next;
              end
            end
          end
          StAckAddr: begin
            if (scl_fall) begin
              if (last_byte[0]) begin
                state_q     <= StRdData;
                shreg       <= rd_data;
                sda_release <= rd_data[7];
              end else begin
                state_q     <= StWrPtr;
                sda_release <= 1'b1;
              end
            end
          end
          StAckWr: begin
            if (scl_fall) begin
              state_q     <= StWrData;
              sda_release <= 1'b1;
            end
          end
          StRdData: begin
            if (scl_rise) begin
              bit_cnt <= bit_cnt + 4'd1;
            end else if (byte_done) begin
              state_q     <= StRdAck;
              sda_release <= 1'b1;
              pointer     <= ptr_next;
              bit_cnt     <= '0;
            end else if (scl_fall) begin
              shreg       <= {shreg[6:0], 1'b0};
              sda_release <= shreg[6];
            end
          end
          StRdAck: begin
            if (scl_rise && sda) begin
              state_q <= StIdle;
            end else if (scl_fall) begin
              state_q     <= StRdData;
              shreg       <= rd_data;
              sda_release <= rd_data[7];
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: rtl/fir_filter_i2c.sv
// 8-tap saturating FIR with an I2C-programmable register file for coefficients and control.
// Tap count, widths and shift come from fir_pkg.
module fir_filter_i2c
  import fir_pkg::*;
#(
  parameter logic [6:0] I2C_ADDR = 7'h50
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [DW-1:0] data_in,
  output logic [DW-1:0] data_out,
  input  logic          i2c_scl_i,
  output logic          i2c_scl_o,
  output logic          i2c_scl_t,
  input  logic          i2c_sda_i,
  output logic          i2c_sda_o,
  output logic          i2c_sda_t,
  output logic [31:0]   testvec
);

  logic [DW-1:0]           x    [TAPS];
  logic [DW-1:0]           coef [TAPS];
  logic signed [ACC_W-1:0] acc, shifted;
  logic [DW-1:0]           sat_val;
  logic                    clip, bypass, sat_flag;
  logic                    wr_en, busy, sda_release;
  logic [7:0]              wr_addr, wr_data, rd_addr, rd_data, last_byte;
  logic [3:0]              fsm_state;

  i2c_reg_target #(
    .I2C_ADDR(I2C_ADDR)
  ) u_i2c (
    .clk        (clk),
    .rst_n      (rst_n),
    .scl_pad    (i2c_scl_i),
    .sda_pad    (i2c_sda_i),
    .sda_release(sda_release),
    .wr_en      (wr_en),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data),
    .rd_addr    (rd_addr),
    .rd_data    (rd_data),
    .last_byte  (last_byte),
    .busy       (busy),
    .state      (fsm_state)
  );

  assign i2c_scl_o = 1'b0;
  assign i2c_scl_t = 1'b1;
  assign i2c_sda_o = 1'b0;
  assign i2c_sda_t = sda_release;
  assign testvec   = {9'd0, fsm_state, bypass, sat_flag, busy, rd_addr, last_byte};

  always_comb begin
    acc = '0;
    for (int k = 0; k < TAPS; k++) begin
      acc = acc + ACC_W'($signed(coef[k])) * ACC_W'($signed(x[k]));
    end
  end

  // Result fits in DW bits only if every bit from the DW-1 sign position upward agrees
  assign shifted = acc >>> SHIFT;
  assign clip    = !((&shifted[ACC_W-1:DW-1]) || !(|shifted[ACC_W-1:DW-1]));
  assign sat_val = !clip            ? shifted[DW-1:0] :
                   shifted[ACC_W-1] ? {1'b1, {(DW-1){1'b0}}} : {1'b0, {(DW-1){1'b1}}};

  always_comb begin
    rd_data = 8'h00;
    if (rd_addr <= COEF_LAST) begin
      rd_data = rd_addr[0] ? coef[rd_addr[3:1]][15:8] : coef[rd_addr[3:1]][7:0];
    end else begin
      case (rd_addr)
        CTRL_ADDR:   rd_data = {7'd0, bypass};
        STATUS_ADDR: rd_data = {7'd0, sat_flag};
        ID_ADDR:     rd_data = ID_VAL;
        default:     rd_data = 8'h00;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < TAPS; k++) begin
        x[k]    <= '0;
        coef[k] <= (k == 0) ? COEF0_RST : '0;
      end
      data_out <= '0;
      bypass   <= 1'b0;
      sat_flag <= 1'b0;
    end else begin
      x[0] <= data_in;
      for (int k = 1; k < TAPS; k++) begin
        x[k] <= x[k-1];
      end
      data_out <= bypass ? x[0] : sat_val;
      if (wr_en && (wr_addr == CTRL_ADDR) && wr_data[1]) begin
        sat_flag <= 1'b0;
      end else if (clip && !bypass) begin
        sat_flag <= 1'b1;
      end
      if (wr_en) begin
        if (wr_addr <= COEF_LAST) begin
          if (wr_addr[0]) coef[wr_addr[3:1]][15:8] <= wr_data;
          else            coef[wr_addr[3:1]][7:0]  <= wr_data;
        end else if (wr_addr == CTRL_ADDR) begin
          bypass <= wr_data[0];
        end
      end
    end
  end

endmodule

// File: tb/tb_fir_filter_i2c.sv
// Directed bench for fir_filter_i2c: a bit-banged I2C master plus datapath stimulus,
// with hand-computed expected values.
module tb_fir_filter_i2c;

  logic        clk;
  logic        rst_n;
  logic [15:0] data_in;
  logic [15:0] data_out;
  logic        scl_o, scl_t, sda_o, sda_t;
  logic [31:0] testvec;
  logic        m_scl, m_sda;
  logic        scl_line, sda_line;
  int          tests;
  int          fails;

  // Open-drain bus: released lines float high
  assign scl_line = m_scl;
  assign sda_line = m_sda & (sda_t | sda_o);

  fir_filter_i2c dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .data_in  (data_in),
    .data_out (data_out),
    .i2c_scl_i(scl_line),
    .i2c_scl_o(scl_o),
    .i2c_scl_t(scl_t),
    .i2c_sda_i(sda_line),
    .i2c_sda_o(sda_o),
    .i2c_sda_t(sda_t),
    .testvec  (testvec)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic i2c_start();
    m_sda = 1'b1; #100;
    m_scl = 1'b1; #100;
    m_sda = 1'b0; #100;
    m_scl = 1'b0; #100;
  endtask

  task automatic i2c_stop();
    m_sda = 1'b0; #100;
    m_scl = 1'b1; #100;
    m_sda = 1'b1; #100;
  endtask

  task automatic put_bit(input logic b);
    m_sda = b;    #100;
    m_scl = 1'b1; #200;
    m_scl = 1'b0; #100;
  endtask

  task automatic get_bit(output logic b);
    m_sda = 1'b1; #100;
    m_scl = 1'b1; #100;
    b = sda_line; #100;
    m_scl = 1'b0; #100;
  endtask

  task automatic put_byte(input logic [7:0] v, output logic ack);
    logic b;
    for (int i = 7; i >= 0; i--) put_bit(v[i]);
    get_bit(b);
    ack = !b;
  endtask

  task automatic get_byte(input logic last, output logic [7:0] v);
    logic b;
    for (int i = 7; i >= 0; i--) begin
      get_bit(b);
      v[i] = b;
    end
    put_bit(last);
  endtask

  task automatic i2c_wr(input logic [7:0] ptr, input int n, input logic [7:0] b0,
                        input logic [7:0] b1, input logic [7:0] b2, input logic [7:0] b3,
                        output int nacks);
    logic [7:0] bs [4];
    logic       a;
    bs = '{b0, b1, b2, b3};
    nacks = 0;
    i2c_start();
    put_byte(8'hA0, a); if (!a) nacks++;
    put_byte(ptr, a);   if (!a) nacks++;
    for (int k = 0; k < n; k++) begin
      put_byte(bs[k], a); if (!a) nacks++;
    end
    i2c_stop();
  endtask

  task automatic i2c_rd(input logic [7:0] ptr, input int n, output logic [7:0] d0,
                        output logic [7:0] d1, output int nacks);
    logic a;
    nacks = 0;
    d1 = 8'h00;
    i2c_start();
    put_byte(8'hA0, a); if (!a) nacks++;
    put_byte(ptr, a);   if (!a) nacks++;
    i2c_start();
    put_byte(8'hA1, a); if (!a) nacks++;
    get_byte(n == 1, d0);
    if (n == 2) get_byte(1'b1, d1);
    i2c_stop();
  endtask

  task automatic settle(input logic [15:0] v);
    data_in = v;
    repeat (12) @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; data_in = '0; m_scl = 1'b1; m_sda = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    tests++; if (testvec !== 32'h0) begin fails++; $display("FAIL reset_testvec got %h want %h", testvec, 32'h0); end
    tests++; if (data_out !== 16'h0) begin fails++; $display("FAIL reset_data_out got %h want %h", data_out, 16'h0); end
    tests++; if (sda_t !== 1'b1) begin fails++; $display("FAIL reset_sda_t got %b want 1", sda_t); end
    tests++; if ({scl_t, scl_o, sda_o} !== 3'b100) begin fails++; $display("FAIL reset_pads got %b want 100", {scl_t, scl_o, sda_o}); end
    rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic test_ramp();
    logic [15:0] exp;
    for (int i = 0; i < 12; i++) begin
      @(posedge clk); #1;
      exp = (i >= 2) ? 16'(i - 2) : 16'h0;
      tests++; if (data_out !== exp) begin fails++; $display("FAIL ramp[%0d] got %h want %h", i, data_out, exp); end
      data_in = 16'(i);
    end
  endtask

  task automatic test_coef_write();
    int          nacks;
    logic [15:0] exp;
    settle(16'h0);
    i2c_wr(8'h00, 4, 8'h00, 8'h20, 8'h00, 8'h20, nacks);
    tests++; if (nacks !== 0) begin fails++; $display("FAIL coef_wr_acks got %0d nacks want 0", nacks); end
    settle(16'h0);
    for (int j = 0; j < 7; j++) begin
      @(posedge clk); #1;
      exp = (j == 2 || j == 3) ? 16'h0800 : 16'h0000;
      tests++; if (data_out !== exp) begin fails++; $display("FAIL impulse[%0d] got %h want %h", j, data_out, exp); end
      data_in = (j == 0) ? 16'h1000 : 16'h0000;
    end
  endtask

  task automatic test_saturation();
    int         nacks;
    logic [7:0] d0, d1;
    i2c_wr(8'h00, 4, 8'hFF, 8'h7F, 8'h00, 8'h00, nacks);
    tests++; if (nacks !== 0) begin fails++; $display("FAIL sat_coef_acks got %0d nacks want 0", nacks); end
    settle(16'h7FFF);
    tests++; if (data_out !== 16'h7FFF) begin fails++; $display("FAIL sat_pos got %h want 7fff", data_out); end
    tests++; if (testvec[17] !== 1'b1) begin fails++; $display("FAIL sat_flag_set got %b want 1", testvec[17]); end
    i2c_rd(8'h11, 1, d0, d1, nacks);
    tests++; if (d0 !== 8'h01) begin fails++; $display("FAIL status_set got %h want 01", d0); end
    settle(16'h0);
    tests++; if (data_out !== 16'h0) begin fails++; $display("FAIL sat_zero got %h want 0000", data_out); end
    i2c_wr(8'h10, 1, 8'h02, 8'h00, 8'h00, 8'h00, nacks);
    tests++; if (testvec[17] !== 1'b0) begin fails++; $display("FAIL sat_flag_clr got %b want 0", testvec[17]); end
    tests++; if (testvec[15:0] !== 16'h1102) begin fails++; $display("FAIL ptr_last_byte got %h want 1102", testvec[15:0]); end
    i2c_rd(8'h11, 1, d0, d1, nacks);
    tests++; if (d0 !== 8'h00) begin fails++; $display("FAIL status_clr got %h want 00", d0); end
    i2c_rd(8'h10, 1, d0, d1, nacks);
    tests++; if (d0 !== 8'h00) begin fails++; $display("FAIL ctrl_selfclr got %h want 00", d0); end
    settle(16'h8000);
    tests++; if (data_out !== 16'h8000) begin fails++; $display("FAIL sat_neg got %h want 8000", data_out); end
    tests++; if (testvec[17] !== 1'b1) begin fails++; $display("FAIL sat_flag_neg got %b want 1", testvec[17]); end
    settle(16'h0);
  endtask

  task automatic test_read();
    int         nacks;
    logic [7:0] d0, d1;
    logic       a;
    i2c_rd(8'h12, 2, d0, d1, nacks);
    tests++; if (nacks !== 0) begin fails++; $display("FAIL id_acks got %0d nacks want 0", nacks); end
    tests++; if (d0 !== 8'hF1) begin fails++; $display("FAIL id_read got %h want f1", d0); end
    tests++; if (d1 !== 8'h00) begin fails++; $display("FAIL id_next got %h want 00", d1); end
    tests++; if (testvec[15:8] !== 8'h14) begin fails++; $display("FAIL id_ptr got %h want 14", testvec[15:8]); end
    i2c_rd(8'h1F, 2, d0, d1, nacks);
    tests++; if ({d0, d1} !== 16'h00FF) begin fails++; $display("FAIL wrap_read got %h want 00ff", {d0, d1}); end
    i2c_start();
    put_byte(8'hA2, a);
    tests++; if (a !== 1'b0) begin fails++; $display("FAIL bad_addr_ack got %b want 0", a); end
    tests++; if (sda_t !== 1'b1) begin fails++; $display("FAIL bad_addr_sda_t got %b want 1", sda_t); end
    tests++; if (testvec[22:19] !== 4'd0) begin fails++; $display("FAIL bad_addr_state got %0d want 0", testvec[22:19]); end
    tests++; if (testvec[16] !== 1'b1) begin fails++; $display("FAIL busy_set got %b want 1", testvec[16]); end
    i2c_stop();
    tests++; if (testvec[16] !== 1'b0) begin fails++; $display("FAIL busy_clr got %b want 0", testvec[16]); end
  endtask

  task automatic test_bypass();
    int          nacks;
    logic [7:0]  d0, d1;
    logic [15:0] tbl [6];
    tbl = '{16'h1234, 16'h8001, 16'h7FFF, 16'hABCD, 16'h0001, 16'hFFFF};
    i2c_wr(8'h10, 1, 8'h01, 8'h00, 8'h00, 8'h00, nacks);
    tests++; if (testvec[18] !== 1'b1) begin fails++; $display("FAIL bypass_bit got %b want 1", testvec[18]); end
    i2c_rd(8'h10, 1, d0, d1, nacks);
    tests++; if (d0 !== 8'h01) begin fails++; $display("FAIL ctrl_read got %h want 01", d0); end
    settle(16'h0);
    for (int j = 0; j < 8; j++) begin
      @(posedge clk); #1;
      if (j >= 2) begin
        tests++;
        if (data_out !== tbl[j-2]) begin fails++; $display("FAIL bypass[%0d] got %h want %h", j, data_out, tbl[j-2]); end
      end
      data_in = (j < 6) ? tbl[j] : 16'h0;
    end
  endtask

  task automatic test_reset_mid_write();
    int         nacks;
    logic [7:0] d0, d1;
    logic       a;
    i2c_start();
    put_byte(8'hA0, a);
    put_byte(8'h00, a);
    for (int i = 7; i >= 0; i--) put_bit(1'(8'h55 >> i));
    m_sda = 1'b1; #100;
    m_scl = 1'b1; #100;
    tests++; if (sda_t !== 1'b0) begin fails++; $display("FAIL mid_ack_drive got %b want 0", sda_t); end
    rst_n = 1'b0; #20;
    tests++; if (testvec !== 32'h0) begin fails++; $display("FAIL mid_rst_testvec got %h want 0", testvec); end
    tests++; if (sda_t !== 1'b1) begin fails++; $display("FAIL mid_rst_sda_t got %b want 1", sda_t); end
    rst_n = 1'b1; #20;
    m_scl = 1'b0; #100;
    i2c_stop();
    i2c_rd(8'h00, 2, d0, d1, nacks);
    tests++; if (nacks !== 0) begin fails++; $display("FAIL post_rst_acks got %0d nacks want 0", nacks); end
    tests++; if ({d1, d0} !== 16'h4000) begin fails++; $display("FAIL post_rst_c0 got %h want 4000", {d1, d0}); end
    settle(16'h0123);
    tests++; if (data_out !== 16'h0123) begin fails++; $display("FAIL post_rst_pass got %h want 0123", data_out); end
  endtask

  initial begin
    tests = 0;
    fails = 0;
    test_reset();
    test_ramp();
    test_coef_write();
    test_saturation();
    test_read();
    test_bypass();
    test_reset_mid_write();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
